// File: rtl/vga_scanout_pkg.sv
// Shared types, timing arithmetic and region-decode helpers for the VGA framebuffer scanout.
package vga_scanout_pkg;

    typedef struct packed {
        logic red;
        logic grn;
        logic blu;
    } rgb_t;

    localparam int unsigned FIFO_DEPTH_MIN = 2;

    function automatic int unsigned line_total(input int unsigned disp, input int unsigned fporch,
                                               input int unsigned sync, input int unsigned bporch);
        return disp + fporch + sync + bporch;
    endfunction

    // Sync pulse starts right after the front porch.
    function automatic int unsigned sync_start(input int unsigned disp,
                                               input int unsigned fporch);
        return disp + fporch;
    endfunction

    function automatic int unsigned words_per_line(input int unsigned box_width,
                                                   input int unsigned word_w);
        return box_width / word_w;
    endfunction

    function automatic int unsigned words_per_frame(input int unsigned box_width,
                                                    input int unsigned word_w,
                                                    input int unsigned box_height);
        return words_per_line(box_width, word_w) * box_height;
    endfunction

    function automatic logic in_window(input int unsigned val, input int unsigned lo,
                                       input int unsigned len);
        return (val >= lo) && (val < lo + len);
    endfunction

endpackage

// File: rtl/fb_word_fifo.sv
// Synchronous prefetch FIFO for framebuffer words, with occupancy count and flush.
module fb_word_fifo
    import vga_scanout_pkg::*;
#(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] pop_data,
    output logic [CNT_W-1:0]  count
);

    logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr;
    logic [PTR_W-1:0]  r_rd;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_pop;
    logic              w_do_push;

    assign w_do_pop  = pop && (r_count != '0);
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign w_do_push = push && ((r_count != CNT_W'(FIFO_DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !reset && !flush) r_mem[r_wr] <= push_data;
    end

    assign pop_data = r_mem[r_rd];
    assign count    = r_count;

endmodule

// File: rtl/vga_fb_scanout.sv
// VGA timing generator with VRAM prefetch and 1-bpp box scanout.
// Define VGA_SCANOUT_BORDER_EN to add border_rgb, which colours active pixels outside the box.
module vga_fb_scanout
    import vga_scanout_pkg::*;
#(
    parameter int unsigned H_DISP     = 1280,
    parameter int unsigned H_FPORCH   = 48,
    parameter int unsigned H_SYNC     = 112,
    parameter int unsigned H_BPORCH   = 248,
    parameter int unsigned V_DISP     = 1024,
    parameter int unsigned V_FPORCH   = 1,
    parameter int unsigned V_SYNC     = 3,
    parameter int unsigned V_BPORCH   = 38,
    parameter int unsigned BOX_X      = 256,
    parameter int unsigned BOX_Y      = 64,
    parameter int unsigned BOX_WIDTH  = 768,
    parameter int unsigned BOX_HEIGHT = 896,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 15,
    parameter bit          SYNC_POL   = 1'b0
) (
`ifdef VGA_SCANOUT_BORDER_EN
    input  logic [2:0]        border_rgb,
`endif
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_req,
    input  logic              vram_ready,
    input  logic [WORD_W-1:0] vram_data,
    output logic              vga_red,
    output logic              vga_grn,
    output logic              vga_blu,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              frame_start,
    output logic              underflow
);

    localparam int unsigned H_TOTAL     = line_total(H_DISP, H_FPORCH, H_SYNC, H_BPORCH);
    localparam int unsigned V_TOTAL     = line_total(V_DISP, V_FPORCH, V_SYNC, V_BPORCH);
    localparam int unsigned HS_START    = sync_start(H_DISP, H_FPORCH);
    localparam int unsigned VS_START    = sync_start(V_DISP, V_FPORCH);
    localparam int unsigned FRAME_WORDS = words_per_frame(BOX_WIDTH, WORD_W, BOX_HEIGHT);
    localparam int unsigned HW          = $clog2(H_TOTAL);
    localparam int unsigned VW          = $clog2(V_TOTAL);
    localparam int unsigned PW          = $clog2(FRAME_WORDS + 1);
    localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1);

    logic [HW-1:0]     r_h;
    logic [VW-1:0]     r_v;
    int unsigned       w_hu;
    int unsigned       w_vu;
    logic              w_active;
    logic              w_in_box;
    logic              w_word_start;
    logic              w_flush;
    logic              w_underrun;
    logic              w_pop;
    logic              w_push;
    logic              w_fetch;
    logic              w_pix;
    logic [CNT_W-1:0]  w_count;
    logic [WORD_W-1:0] w_head;
    logic [WORD_W-1:0] r_shift;
    logic              r_dead;
    logic [PW-1:0]     r_ptr;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    rgb_t              w_rgb;
    rgb_t              r_rgb;
    logic              r_hsync;
    logic              r_vsync;
    logic              r_frame_start;
    logic              r_underflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == HW'(H_TOTAL - 1)) begin
            r_h <= '0;
            r_v <= (r_v == VW'(V_TOTAL - 1)) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    assign w_hu         = 32'(r_h);
    assign w_vu         = 32'(r_v);
    assign w_active     = in_window(w_hu, 0, H_DISP) && in_window(w_vu, 0, V_DISP);
    assign w_in_box     = w_active && in_window(w_hu, BOX_X, BOX_WIDTH)
                          && in_window(w_vu, BOX_Y, BOX_HEIGHT);
    assign w_word_start = w_in_box && (((w_hu - BOX_X) % WORD_W) == 0);
    assign w_flush      = (w_vu == V_DISP) && (r_h == '0);

    // Once a frame has starved, later word boundaries neither pop nor re-flag.
    assign w_underrun   = w_word_start && !r_dead && (w_count == '0);
    assign w_pop        = w_word_start && !r_dead && (w_count != '0);
    assign w_push       = r_req && vram_ready && !w_flush;
    assign w_fetch      = !r_req && !r_dead && !w_underrun && !w_flush
                          && (w_count < CNT_W'(FIFO_DEPTH)) && (r_ptr < PW'(FRAME_WORDS));

    fb_word_fifo #(
        .WORD_W    (WORD_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (w_flush),
        .push     (w_push),
        .push_data(vram_data),
        .pop      (w_pop),
        .pop_data (w_head),
        .count    (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req  <= 1'b0;
            r_addr <= '0;
            r_ptr  <= '0;
        end else if (w_flush) begin
            r_req <= 1'b0;
            r_ptr <= '0;
        end else if (w_push) begin
            r_req <= 1'b0;
            r_ptr <= r_ptr + 1'b1;
        end else if (w_fetch) begin
            r_req  <= 1'b1;
            r_addr <= ADDR_W'(r_ptr);
        end
    end

    assign w_pix = w_pop ? w_head[0] : r_shift[0];

    always_comb begin
        w_rgb = '0;
        if (w_in_box) begin
            if (!r_dead && !w_underrun && w_pix) w_rgb = rgb_t'(3'b111);
        end else if (w_active) begin
`ifdef VGA_SCANOUT_BORDER_EN
            w_rgb = rgb_t'(border_rgb);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rgb         <= '0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
            r_dead        <= 1'b0;
            r_shift       <= '0;
        end else begin
            r_rgb         <= w_rgb;
            r_hsync       <= in_window(w_hu, HS_START, H_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= in_window(w_vu, VS_START, V_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_frame_start <= (r_h == '0) && (r_v == '0);
            if (w_underrun) r_underflow <= 1'b1;
            if (w_flush)         r_dead <= 1'b0;
            else if (w_underrun) r_dead <= 1'b1;
            r_shift <= w_pop ? (w_head >> 1) : (r_shift >> 1);
        end
    end

    assign vram_req    = r_req;
    assign vram_addr   = r_addr;
    assign vga_red     = r_rgb.red;
    assign vga_grn     = r_rgb.grn;
    assign vga_blu     = r_rgb.blu;
    assign vga_hsync   = r_hsync;
    assign vga_vsync   = r_vsync;
    assign frame_start = r_frame_start;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench for vga_fb_scanout on a 22x11 raster with an 8x4 box of 4-bit words at (4,2).
module tb_vga_fb_scanout;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] vram_addr;
    logic       vram_req;
    logic       vram_ready;
    logic [3:0] vram_data;
    logic       vga_red, vga_grn, vga_blu, vga_hsync, vga_vsync, frame_start, underflow;
`ifdef VGA_SCANOUT_BORDER_EN
    logic [2:0] border_rgb = 3'b100;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = -1;
    int resp_delay = 1;
    bit withhold = 1'b0;
    int wait_cnt = 0;

    always #5 clk = ~clk;

    vga_fb_scanout #(
        .H_DISP(16), .H_FPORCH(2), .H_SYNC(2), .H_BPORCH(2),
        .V_DISP(8), .V_FPORCH(1), .V_SYNC(1), .V_BPORCH(1),
        .BOX_X(4), .BOX_Y(2), .BOX_WIDTH(8), .BOX_HEIGHT(4),
        .WORD_W(4), .FIFO_DEPTH(2), .ADDR_W(8), .SYNC_POL(1'b0)
    ) u_dut (
`ifdef VGA_SCANOUT_BORDER_EN
        .border_rgb (border_rgb),
`endif
        .clk        (clk),
        .reset      (reset),
        .vram_addr  (vram_addr),
        .vram_req   (vram_req),
        .vram_ready (vram_ready),
        .vram_data  (vram_data),
        .vga_red    (vga_red),
        .vga_grn    (vga_grn),
        .vga_blu    (vga_blu),
        .vga_hsync  (vga_hsync),
        .vga_vsync  (vga_vsync),
        .frame_start(frame_start),
        .underflow  (underflow)
    );

    // Output index: after the k-th edge out of reset the outputs show raster position k.
    always @(posedge clk) begin
        if (reset) cyc <= -1;
        else       cyc <= cyc + 1;
    end

    // VRAM model: word n holds value n; answers resp_delay cycles after req is seen.
    initial begin
        vram_ready = 1'b0;
        vram_data  = '0;
        forever begin
            @(negedge clk);
            vram_ready = 1'b0;
            if (vram_req && !withhold) begin
                if (wait_cnt >= resp_delay) begin
                    vram_ready = 1'b1;
                    vram_data  = 4'(vram_addr);
                    wait_cnt   = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    function automatic logic [2:0] exp_rgb(input int idx, input bit dead);
        int f, h, v, x, y, word;
        f = idx % 242;
        h = f % 22;
        v = f / 22;
        if (h >= 4 && h < 12 && v >= 2 && v < 6) begin
            if (dead) return 3'b000;
            x    = h - 4;
            y    = v - 2;
            word = y * 2 + x / 4;
            return (((word >> (x % 4)) & 1) != 0) ? 3'b111 : 3'b000;
        end
`ifdef VGA_SCANOUT_BORDER_EN
        if (h < 16 && v < 8) return 3'b100;
`endif
        return 3'b000;
    endfunction

    function automatic logic exp_hsync(input int idx);
        int h;
        h = (idx % 242) % 22;
        return !(h == 18 || h == 19);
    endfunction

    function automatic logic exp_vsync(input int idx);
        return ((idx % 242) / 22) != 9;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (vram_req !== 1'b0) begin
            errors++; $display("FAIL reset_req: got %b expected 0", vram_req);
        end
        checks++;
        if (vram_addr !== 8'd0) begin
            errors++; $display("FAIL reset_addr: got %0d expected 0", vram_addr);
        end
        checks++;
        if ({vga_red, vga_grn, vga_blu} !== 3'b000) begin
            errors++; $display("FAIL reset_rgb: got %b expected 000", {vga_red, vga_grn, vga_blu});
        end
        checks++;
        if ({vga_hsync, vga_vsync} !== 2'b11) begin
            errors++; $display("FAIL reset_sync: got %b expected 11", {vga_hsync, vga_vsync});
        end
        checks++;
        if ({frame_start, underflow} !== 2'b00) begin
            errors++; $display("FAIL reset_flags: got %b expected 00", {frame_start, underflow});
        end
        reset = 1'b0;
    endtask

    task automatic test_timing();
        resp_delay = 1;
        for (int i = 0; i < 484; i++) begin
            @(negedge clk);
            checks++;
            if ({vga_hsync, vga_vsync, frame_start} !==
                {exp_hsync(cyc), exp_vsync(cyc), 1'((cyc % 242) == 0)}) begin
                errors++;
                $display("FAIL timing_sync idx=%0d: got %b expected %b", cyc,
                         {vga_hsync, vga_vsync, frame_start},
                         {exp_hsync(cyc), exp_vsync(cyc), 1'((cyc % 242) == 0)});
            end
            checks++;
            if ({vga_red, vga_grn, vga_blu} !== exp_rgb(cyc, 1'b0) || underflow !== 1'b0) begin
                errors++;
                $display("FAIL timing_video idx=%0d: got rgb %b uf %b expected rgb %b uf 0", cyc,
                         {vga_red, vga_grn, vga_blu}, underflow, exp_rgb(cyc, 1'b0));
            end
        end
    endtask

    task automatic test_data_mapping();
        logic [7:0] line0_r, line0_gb;
        logic [3:0] line1_r, line1_gb;
        for (int i = 0; i < 300 && (cyc % 242) != 48; i++) @(negedge clk);
        checks++;
        if ((cyc % 242) != 48) begin
            errors++; $display("FAIL map_sync0: got idx %0d expected 48", cyc % 242);
        end
        for (int i = 0; i < 8; i++) begin
            line0_r[i]  = vga_red;
            line0_gb[i] = vga_grn & vga_blu;
            @(negedge clk);
        end
        for (int i = 0; i < 300 && (cyc % 242) != 70; i++) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            line1_r[i]  = vga_red;
            line1_gb[i] = vga_grn & vga_blu;
            @(negedge clk);
        end
        checks++;
        if (line0_r !== 8'b0001_0000) begin
            errors++; $display("FAIL map_line0_red: got %b expected 00010000", line0_r);
        end
        checks++;
        if (line0_gb !== 8'b0001_0000) begin
            errors++; $display("FAIL map_line0_gb: got %b expected 00010000", line0_gb);
        end
        checks++;
        if (line1_r !== 4'b0010) begin
            errors++; $display("FAIL map_line1_red: got %b expected 0010", line1_r);
        end
        checks++;
        if (line1_gb !== 4'b0010) begin
            errors++; $display("FAIL map_line1_gb: got %b expected 0010", line1_gb);
        end
    endtask

    task automatic test_backpressure();
        logic       prev_req = 1'b0;
        logic [7:0] prev_addr = '0;
        resp_delay = 3;
        for (int i = 0; i < 484; i++) begin
            @(negedge clk);
            checks++;
            if ({vga_red, vga_grn, vga_blu} !== exp_rgb(cyc, 1'b0) || underflow !== 1'b0) begin
                errors++;
                $display("FAIL bp_video idx=%0d: got rgb %b uf %b expected rgb %b uf 0", cyc,
                         {vga_red, vga_grn, vga_blu}, underflow, exp_rgb(cyc, 1'b0));
            end
            checks++;
            if (vram_req === 1'b1 && u_dut.w_count == 2'd2) begin
                errors++; $display("FAIL bp_req_full idx=%0d: got req 1 expected 0", cyc);
            end
            if (prev_req && vram_req) begin
                checks++;
                if (vram_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL bp_addr_stable idx=%0d: got %0d expected %0d", cyc,
                             vram_addr, prev_addr);
                end
            end
            prev_req  = vram_req;
            prev_addr = vram_addr;
        end
        resp_delay = 1;
    endtask

    task automatic test_underflow();
        int  phase = 0;
        int  f;
        bit  exp_uf;
        for (int i = 0; i < 300 && (cyc % 242) != 170; i++) @(negedge clk);
        checks++;
        if ((cyc % 242) != 170) begin
            errors++; $display("FAIL uf_sync: got idx %0d expected 170", cyc % 242);
        end
        // Starve from just before the vblank flush until well past the first box word.
        withhold = 1'b1;
        for (int i = 0; i < 700 && phase < 3; i++) begin
            @(negedge clk);
            f = cyc % 242;
            if (f == 0) phase++;
            if (phase == 1 && f == 60) withhold = 1'b0;
            if (phase < 3) begin
                exp_uf = (phase >= 2) || (phase == 1 && f >= 48);
                checks++;
                if ({vga_red, vga_grn, vga_blu} !== exp_rgb(cyc, phase == 1)) begin
                    errors++;
                    $display("FAIL uf_rgb phase=%0d idx=%0d: got %b expected %b", phase, f,
                             {vga_red, vga_grn, vga_blu}, exp_rgb(cyc, phase == 1));
                end
                checks++;
                if (underflow !== exp_uf) begin
                    errors++;
                    $display("FAIL uf_flag phase=%0d idx=%0d: got %b expected %b", phase, f,
                             underflow, exp_uf);
                end
            end
        end
        withhold = 1'b0;
        checks++;
        if (phase != 3) begin
            errors++; $display("FAIL uf_frames: got %0d frame starts expected 3", phase);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 300 && !(vram_req === 1'b1); i++) @(negedge clk);
        checks++;
        if (vram_req !== 1'b1) begin
            errors++; $display("FAIL rm_wait_req: got %b expected 1", vram_req);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (vram_req !== 1'b0) begin
            errors++; $display("FAIL rm_req: got %b expected 0", vram_req);
        end
        checks++;
        if ({vga_hsync, vga_vsync, vga_red, vga_grn, vga_blu} !== 5'b11000) begin
            errors++;
            $display("FAIL rm_video: got %b expected 11000",
                     {vga_hsync, vga_vsync, vga_red, vga_grn, vga_blu});
        end
        checks++;
        if ({frame_start, underflow} !== 2'b00) begin
            errors++; $display("FAIL rm_flags: got %b expected 00", {frame_start, underflow});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b1) begin
            errors++; $display("FAIL rm_fs_first: got %b expected 1", frame_start);
        end
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b0) begin
            errors++; $display("FAIL rm_fs_second: got %b expected 0", frame_start);
        end
    endtask

    task automatic test_border();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            checks++;
            if ({vga_red, vga_grn, vga_blu} !== exp_rgb(cyc, 1'b0)) begin
                errors++;
                $display("FAIL border_rgb idx=%0d: got %b expected %b", cyc,
                         {vga_red, vga_grn, vga_blu}, exp_rgb(cyc, 1'b0));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_timing();
        test_data_mapping();
        test_backpressure();
        test_underflow();
        test_reset_mid();
        test_border();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
